param_cpu_core: RTL and testbench

//  Parametrised accumulator CPU core: registers A, B, carry flag C, PC and an output latch, driven by an

---
 rtl/param_cpu_core.sv | 207 ++++++++++++++++++++
 tb/tb_param_cpu_core.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_cpu_core.sv
`default_nettype none
// ============================================================================
// Module      : param_cpu_core
// Description : Parametrised single-cycle accumulator CPU. Registers A, B,
//               carry flag, PC and an output latch, fetching from an external
//               combinational ROM. Supports free-run and single-step modes,
//               halt on self-jump, illegal-opcode flagging and a retired-
//               instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module param_cpu_core #(
    parameter int DATA_W = 4,
    parameter int PC_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              run_mode,
    input  logic              step,
    input  logic [DATA_W+3:0] inst,
    input  logic [DATA_W-1:0] io_in,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] io_out,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic              carry,
    output logic              halted,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    // Execution-control states
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_STEP = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Opcode map
    localparam logic [3:0] c_op_add_a  = 4'b0000;
    localparam logic [3:0] c_op_mov_ab = 4'b0001;
    localparam logic [3:0] c_op_in_a   = 4'b0010;
    localparam logic [3:0] c_op_mov_ai = 4'b0011;
    localparam logic [3:0] c_op_mov_ba = 4'b0100;
    localparam logic [3:0] c_op_add_b  = 4'b0101;
    localparam logic [3:0] c_op_in_b   = 4'b0110;
    localparam logic [3:0] c_op_mov_bi = 4'b0111;
    localparam logic [3:0] c_op_out_b  = 4'b1001;
    localparam logic [3:0] c_op_out_i  = 4'b1011;
    localparam logic [3:0] c_op_jnc    = 4'b1110;
    localparam logic [3:0] c_op_jmp    = 4'b1111;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_step_pend;
    logic                w_step_pend_nxt;

    logic [PC_W-1:0]     r_pc;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_io_out;
    logic                r_carry;
    logic [CNT_W-1:0]    r_retired;

    logic [3:0]          w_opcode;
    logic [DATA_W-1:0]   w_imm;
    logic [PC_W-1:0]     w_jmp_tgt;
    logic [DATA_W:0]     w_sum_a;
    logic [DATA_W:0]     w_sum_b;
    logic                w_exec;
    logic                w_jump_taken;
    logic                w_self_jump;
    logic                w_undef;
    logic [PC_W-1:0]     w_pc_nxt;
    logic [DATA_W-1:0]   w_a_nxt;
    logic [DATA_W-1:0]   w_b_nxt;
    logic [DATA_W-1:0]   w_io_nxt;
    logic                w_c_nxt;

    assign w_opcode = inst[DATA_W+3:DATA_W];
    assign w_imm    = inst[DATA_W-1:0];

    // The immediate is the jump target; adapt it to the PC width
    if (PC_W > DATA_W) begin : g_tgt_ext
        assign w_jmp_tgt = {{(PC_W-DATA_W){1'b0}}, w_imm};
    end else begin : g_tgt_trunc
        assign w_jmp_tgt = w_imm[PC_W-1:0];
    end

    // Adders keep the carry-out in the top bit
    assign w_sum_a = {1'b0, r_a} + {1'b0, w_imm};
    assign w_sum_b = {1'b0, r_b} + {1'b0, w_imm};

    // An instruction executes on a tick while running, or on a tick with a latched step request
    assign w_exec = tick && ((r_state == ST_RUN) || ((r_state == ST_STEP) && r_step_pend));

    // A taken jump onto its own address parks the core
    assign w_self_jump = w_jump_taken && (w_jmp_tgt == r_pc);

    // Instruction decode: next architectural values if the current instruction executes
    always_comb begin
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_io_nxt     = r_io_out;
        w_c_nxt      = 1'b0;
        w_pc_nxt     = r_pc + PC_W'(1);
        w_jump_taken = 1'b0;
        w_undef      = 1'b0;
        case (w_opcode)
            c_op_add_a:  {w_c_nxt, w_a_nxt} = w_sum_a;
            c_op_add_b:  {w_c_nxt, w_b_nxt} = w_sum_b;
            c_op_mov_ai: w_a_nxt = w_imm;
            c_op_mov_bi: w_b_nxt = w_imm;
            c_op_mov_ab: w_a_nxt = r_b;
            c_op_mov_ba: w_b_nxt = r_a;
            c_op_in_a:   w_a_nxt = io_in;
            c_op_in_b:   w_b_nxt = io_in;
            c_op_out_b:  w_io_nxt = r_b;
            c_op_out_i:  w_io_nxt = w_imm;
            c_op_jmp:    w_jump_taken = 1'b1;
            c_op_jnc:    w_jump_taken = ~r_carry;
            default:     w_undef = 1'b1;
        endcase
        if (w_jump_taken) begin
            w_pc_nxt = w_jmp_tgt;
        end
    end

    // Control state and step-request register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= run_mode ? ST_RUN : ST_STEP;
            r_step_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_step_pend <= w_step_pend_nxt;
        end
    end

    // Next control state; halting takes priority over mode changes, the old state governs this tick
    always_comb begin
        w_state_nxt     = r_state;
        w_step_pend_nxt = r_step_pend;
        case (r_state)
            ST_RUN: begin
                w_step_pend_nxt = 1'b0;
                if (w_exec && w_self_jump) begin
                    w_state_nxt = ST_HALT;
                end else if (!run_mode) begin
                    w_state_nxt = ST_STEP;
                end
            end
            ST_STEP: begin
                if (w_exec && w_self_jump) begin
                    w_state_nxt     = ST_HALT;
                    w_step_pend_nxt = 1'b0;
                end else if (run_mode) begin
                    w_state_nxt     = ST_RUN;
                    w_step_pend_nxt = 1'b0;
                end else if (w_exec) begin
                    w_step_pend_nxt = 1'b0;
                end else if (step) begin
                    w_step_pend_nxt = 1'b1;
                end
            end
            ST_HALT: begin
                w_step_pend_nxt = 1'b0;
            end
            default: begin
                w_state_nxt     = ST_RUN;
                w_step_pend_nxt = 1'b0;
            end
        endcase
    end

    // Architectural registers update only on an executing cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_io_out  <= '0;
            r_carry   <= 1'b0;
            r_retired <= '0;
        end else if (w_exec) begin
            r_pc      <= w_pc_nxt;
            r_a       <= w_a_nxt;
            r_b       <= w_b_nxt;
            r_io_out  <= w_io_nxt;
            r_carry   <= w_c_nxt;
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign pc      = r_pc;
    assign io_out  = r_io_out;
    assign reg_a   = r_a;
    assign reg_b   = r_b;
    assign carry   = r_carry;
    assign retired = r_retired;
    assign halted  = (r_state == ST_HALT);
    // Flag is tied to the executing cycle itself, so it is naturally 0 on every other cycle
    assign illegal = w_exec && w_undef && !reset;

endmodule
`default_nettype wire

// File: tb/tb_param_cpu_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_cpu_core
// Description : Scoreboard bench for param_cpu_core (DATA_W=4, PC_W=6,
//               CNT_W=8). Directed programs plus randomized programs and
//               control inputs, compared against an ISA-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_cpu_core;

    localparam int DW = 4;
    localparam int PW = 6;
    localparam int CW = 8;
    localparam int M_RUN  = 0;
    localparam int M_STEP = 1;
    localparam int M_HALT = 2;

    logic            clk;
    logic            reset;
    logic            tick;
    logic            run_mode;
    logic            step;
    logic [DW+3:0]   inst;
    logic [DW-1:0]   io_in;
    logic [PW-1:0]   pc;
    logic [DW-1:0]   io_out;
    logic [DW-1:0]   reg_a;
    logic [DW-1:0]   reg_b;
    logic            carry;
    logic            halted;
    logic            illegal;
    logic [CW-1:0]   retired;

    logic [7:0]      rom [0:63];

    typedef struct {
        int pc;
        int a;
        int b;
        int c;
        int io;
        int halted;
        int ill;
        int ret;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    int   m_pc, m_a, m_b, m_c, m_io, m_ret, m_mode, m_pend;
    bit   m_valid = 0;

    param_cpu_core #(
        .DATA_W (DW),
        .PC_W   (PW),
        .CNT_W  (CW)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .run_mode (run_mode),
        .step     (step),
        .inst     (inst),
        .io_in    (io_in),
        .pc       (pc),
        .io_out   (io_out),
        .reg_a    (reg_a),
        .reg_b    (reg_b),
        .carry    (carry),
        .halted   (halted),
        .illegal  (illegal),
        .retired  (retired)
    );

    assign inst = rom[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; records what the DUT should show during it, then advances the model
    task automatic cyc(input bit rst, input bit tk, input bit rm, input bit st, input int io);
        exp_t e;
        int   op, im, s, npc, nc;
        bit   ex, jt, ill;
        @(posedge clk);
        #1;
        reset    = rst;
        tick     = tk;
        run_mode = rm;
        step     = st;
        io_in    = 4'(io);
        op = 0; im = 0; jt = 0; ill = 0; npc = 0; nc = 0;
        ex = !rst && tk && (m_mode == M_RUN || (m_mode == M_STEP && m_pend == 1));
        if (ex) begin
            op  = int'(rom[m_pc]) / 16;
            im  = int'(rom[m_pc]) % 16;
            ill = !(op inside {0, 1, 2, 3, 4, 5, 6, 7, 9, 11, 14, 15});
        end
        if (m_valid) begin
            e.pc = m_pc; e.a = m_a; e.b = m_b; e.c = m_c; e.io = m_io;
            e.halted = (m_mode == M_HALT); e.ill = ill; e.ret = m_ret;
            q.push_back(e);
        end
        if (rst) begin
            m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_io = 0; m_ret = 0;
            m_mode = rm ? M_RUN : M_STEP;
            m_pend = 0;
            m_valid = 1;
        end else begin
            if (ex) begin
                npc = (m_pc + 1) % 64;
                case (op)
                    0:  begin s = m_a + im; m_a = s % 16; nc = s / 16; end
                    5:  begin s = m_b + im; m_b = s % 16; nc = s / 16; end
                    3:  m_a = im;
                    7:  m_b = im;
                    1:  m_a = m_b;
                    4:  m_b = m_a;
                    2:  m_a = io % 16;
                    6:  m_b = io % 16;
                    9:  m_io = m_b;
                    11: m_io = im;
                    15: jt = 1;
                    14: jt = (m_c == 0);
                    default: ;
                endcase
                if (jt) npc = im;
                m_ret = (m_ret + 1) % 256;
            end
            if (m_mode == M_HALT) begin
            end else if (ex && jt && im == m_pc) begin
                m_mode = M_HALT;
                m_pend = 0;
            end else if (m_mode == M_RUN) begin
                if (!rm) m_mode = M_STEP;
            end else begin
                if (rm) begin
                    m_mode = M_RUN;
                    m_pend = 0;
                end else if (ex) begin
                    m_pend = 0;
                end else if (st) begin
                    m_pend = 1;
                end
            end
            if (ex) begin
                m_pc = npc;
                m_c  = nc;
            end
        end
    endtask

    // Reset cycle with no tick, so the ROM may be rewritten safely right after it
    task automatic quiesce(input bit rm);
        cyc(1, 0, rm, 0, 0);
    endtask

    task automatic fill_rom(input logic [7:0] v);
        for (int i = 0; i < 64; i++) rom[i] = v;
    endtask

    // Monitor: every cycle the DUT presents its state; compare against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc",      32'(pc),      e.pc);
                chk("reg_a",   32'(reg_a),   e.a);
                chk("reg_b",   32'(reg_b),   e.b);
                chk("carry",   32'(carry),   e.c);
                chk("io_out",  32'(io_out),  e.io);
                chk("halted",  32'(halted),  e.halted);
                chk("illegal", 32'(illegal), e.ill);
                chk("retired", 32'(retired), e.ret);
            end
        end
    end

    initial begin
        reset = 1'b1; tick = 1'b0; run_mode = 1'b1; step = 1'b0; io_in = '0;
        fill_rom(8'h80);

        // Basic run: MOV A,3; ADD A,2; halt
        quiesce(1);
        rom[0] = 8'h33; rom[1] = 8'h02; rom[2] = 8'hF2;
        quiesce(1);
        for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 0);

        // Carry generation and JNC fall-through
        quiesce(1);
        fill_rom(8'h80);
        rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'hE0; rom[3] = 8'hF3;
        quiesce(1);
        for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 0);

        // Single-step: ticks without step, step then ticks, double step
        quiesce(0);
        fill_rom(8'h80);
        rom[0] = 8'h33; rom[1] = 8'h35; rom[2] = 8'h01; rom[3] = 8'h40;
        quiesce(0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);

        // Halt on self-jump at pc=6, then poke every control input
        quiesce(1);
        fill_rom(8'h80);
        for (int i = 0; i < 6; i++) rom[i] = 8'(8'h31 + i);
        rom[6] = 8'hF6;
        quiesce(1);
        for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, i % 2, i % 3 == 0, 0);

        // Illegal opcode at pc=2
        quiesce(1);
        fill_rom(8'h80);
        rom[0] = 8'h35; rom[1] = 8'h7A; rom[2] = 8'h80; rom[3] = 8'hB6; rom[4] = 8'hF4;
        quiesce(1);
        for (int i = 0; i < 7; i++) cyc(0, 1, 1, 0, 0);

        // Wide PC: jump, IN/OUT B, wrap past 63, retired counter wrap
        quiesce(1);
        fill_rom(8'hC0);
        rom[0] = 8'hFA; rom[10] = 8'h60; rom[11] = 8'h90; rom[12] = 8'hFF;
        quiesce(1);
        for (int i = 0; i < 300; i++) cyc(0, 1, 1, 0, 9);

        // Randomized programs and control
        for (int r = 0; r < 5; r++) begin
            bit rm;
            rm = 1'($urandom_range(0, 1));
            quiesce(rm);
            for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
            quiesce(rm);
            for (int i = 0; i < 500; i++) begin
                bit rst;
                if ($urandom_range(0, 49) == 0) rm = ~rm;
                rst = (m_mode == M_HALT) ? ($urandom_range(0, 19) == 0)
                                         : ($urandom_range(0, 1999) == 0);
                cyc(rst, 1'($urandom_range(0, 1)), rm,
                    $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)));
            end
        end

        // Reset in the same cycle as a would-be exec
        cyc(1, 1, 1, 1, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
